// File: rtl/sobel_fold_engine.sv
`default_nettype none
// ============================================================================
// Module      : sobel_fold_engine
// Description : 3x3 Sobel/Prewitt gradient engine, folded onto one multiplier
//               per direction (one tap per cycle), with threshold edge output.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_fold_engine #(
    parameter int PIX_W = 8,
    parameter int MAG_W = PIX_W + 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [9*PIX_W-1:0]   i_px,
    input  logic                 i_kern_sel,
    input  logic                 i_mag_sel,
    input  logic [MAG_W-1:0]     i_thresh,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [MAG_W-1:0]     o_mag,
    output logic [PIX_W-1:0]     o_pix_clip,
    output logic                 o_edge
);

    localparam int C_PRD_W = PIX_W + 3;
    localparam int C_ACC_W = PIX_W + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [3:0]                 r_tap;
    logic [9*PIX_W-1:0]         r_px;
    logic                       r_kern;
    logic                       r_msel;
    logic signed [C_ACC_W-1:0]  r_acc_x;
    logic signed [C_ACC_W-1:0]  r_acc_y;
    logic [MAG_W-1:0]           r_mag;
    logic [PIX_W-1:0]           r_clip;

    logic [PIX_W-1:0]           w_pix;
    logic signed [2:0]          w_w;
    logic signed [2:0]          w_wx;
    logic signed [2:0]          w_wy;
    logic signed [PIX_W:0]      w_pix_s;
    logic signed [C_PRD_W-1:0]  w_pix_e;
    logic signed [C_PRD_W-1:0]  w_wx_e;
    logic signed [C_PRD_W-1:0]  w_wy_e;
    logic signed [C_PRD_W-1:0]  w_prod_x;
    logic signed [C_PRD_W-1:0]  w_prod_y;
    logic signed [C_ACC_W-1:0]  w_abs_x;
    logic signed [C_ACC_W-1:0]  w_abs_y;
    logic [MAG_W-1:0]           w_ax;
    logic [MAG_W-1:0]           w_ay;
    logic [MAG_W-1:0]           w_mag_n;
    logic [PIX_W-1:0]           w_clip_n;

    // Side weight: 2 for Sobel, 1 for Prewitt
    assign w_w = r_kern ? 3'sd1 : 3'sd2;

    always_comb begin
        w_pix = '0;
        w_wx  = 3'sd0;
        w_wy  = 3'sd0;
        case (r_tap)
            4'd1: begin w_pix = r_px[0*PIX_W +: PIX_W]; w_wx = -3'sd1; w_wy =  3'sd1; end
            4'd2: begin w_pix = r_px[1*PIX_W +: PIX_W]; w_wx =  3'sd0; w_wy =  w_w;   end
            4'd3: begin w_pix = r_px[2*PIX_W +: PIX_W]; w_wx =  3'sd1; w_wy =  3'sd1; end
            4'd4: begin w_pix = r_px[3*PIX_W +: PIX_W]; w_wx = -w_w;   w_wy =  3'sd0; end
            4'd5: begin w_pix = r_px[4*PIX_W +: PIX_W]; w_wx =  3'sd0; w_wy =  3'sd0; end
            4'd6: begin w_pix = r_px[5*PIX_W +: PIX_W]; w_wx =  w_w;   w_wy =  3'sd0; end
            4'd7: begin w_pix = r_px[6*PIX_W +: PIX_W]; w_wx = -3'sd1; w_wy = -3'sd1; end
            4'd8: begin w_pix = r_px[7*PIX_W +: PIX_W]; w_wx =  3'sd0; w_wy = -w_w;   end
            4'd9: begin w_pix = r_px[8*PIX_W +: PIX_W]; w_wx =  3'sd1; w_wy = -3'sd1; end
            default: ;
        endcase
    end

    assign w_pix_s  = {1'b0, w_pix};
    assign w_pix_e  = C_PRD_W'(w_pix_s);
    assign w_wx_e   = C_PRD_W'(w_wx);
    assign w_wy_e   = C_PRD_W'(w_wy);
    assign w_prod_x = w_pix_e * w_wx_e;
    assign w_prod_y = w_pix_e * w_wy_e;

    // |G| never exceeds 4*(2^PIX_W-1), so the low MAG_W bits hold it exactly
    assign w_abs_x  = r_acc_x[C_ACC_W-1] ? -r_acc_x : r_acc_x;
    assign w_abs_y  = r_acc_y[C_ACC_W-1] ? -r_acc_y : r_acc_y;
    assign w_ax     = w_abs_x[MAG_W-1:0];
    assign w_ay     = w_abs_y[MAG_W-1:0];
    assign w_mag_n  = r_msel ? ((w_ax >= w_ay) ? w_ax : w_ay) : (w_ax + w_ay);
    assign w_clip_n = (|w_mag_n[MAG_W-1:PIX_W]) ? {PIX_W{1'b1}} : w_mag_n[PIX_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_next = S_MAC;
            end
            S_MAC:  if (r_tap == 4'd9) w_next = S_FIN;
            S_FIN:  w_next = S_HOLD;
            S_HOLD: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Window and modes are captured once at accept; no reset needed
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && i_in_valid) begin
            r_px   <= i_px;
            r_kern <= i_kern_sel;
            r_msel <= i_mag_sel;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tap   <= 4'd0;
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_mag   <= '0;
            r_clip  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_tap   <= 4'd1;
                        r_acc_x <= '0;
                        r_acc_y <= '0;
                    end
                end
                S_MAC: begin
                    r_acc_x <= r_acc_x + C_ACC_W'(w_prod_x);
                    r_acc_y <= r_acc_y + C_ACC_W'(w_prod_y);
                    r_tap   <= (r_tap == 4'd9) ? 4'd0 : r_tap + 4'd1;
                end
                S_FIN: begin
                    r_mag  <= w_mag_n;
                    r_clip <= w_clip_n;
                end
                default: ;
            endcase
        end
    end

    // Edge tracks the live threshold and is held low whenever no result is shown
    assign o_mag      = r_mag;
    assign o_pix_clip = r_clip;
    assign o_edge     = o_out_valid & (r_mag >= i_thresh);

endmodule
`default_nettype wire

// File: tb/tb_sobel_fold_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_fold_engine
// Description : Directed scoreboard bench for sobel_fold_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_fold_engine;

    localparam int PIX_W = 8;
    localparam int MAG_W = PIX_W + 3;

    logic               clk       = 1'b0;
    logic               reset     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               kern_sel  = 1'b0;
    logic               mag_sel   = 1'b0;
    logic               out_ready = 1'b1;
    logic [9*PIX_W-1:0] px        = '0;
    logic [MAG_W-1:0]   thresh    = '0;
    logic               in_ready;
    logic               out_valid;
    logic               edge_flag;
    logic [MAG_W-1:0]   mag;
    logic [PIX_W-1:0]   pix_clip;

    typedef struct {
        int mag;
        int t;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   xfers  = 0;
    bit   shown  = 1'b0;

    sobel_fold_engine #(.PIX_W(PIX_W), .MAG_W(MAG_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_px        (px),
        .i_kern_sel  (kern_sel),
        .i_mag_sel   (mag_sel),
        .i_thresh    (thresh),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_mag       (mag),
        .o_pix_clip  (pix_clip),
        .o_edge      (edge_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input logic [9*PIX_W-1:0] p, input bit k, input bit ms);
        int v[9];
        int w, gx, gy;
        for (int i = 0; i < 9; i++) v[i] = int'(p[i*PIX_W +: PIX_W]);
        w  = k ? 1 : 2;
        gx = -v[0] + v[2] - w*v[3] + w*v[5] - v[6] + v[8];
        gy =  v[0] + w*v[1] + v[2] - v[6] - w*v[7] - v[8];
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return ms ? ((gx > gy) ? gx : gy) : (gx + gy);
    endfunction

    function automatic logic [9*PIX_W-1:0] win(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Scoreboard: push on accept, compare every presented cycle, pop on transfer
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            shown = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                e.mag = model(px, kern_sel, mag_sel);
                e.t   = cyc;
                sb.push_back(e);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    if (!shown) chk("latency", cyc - sb[0].t, 11);
                    chk("mag", mag, sb[0].mag);
                    chk("pix_clip", pix_clip, (sb[0].mag > 255) ? 255 : sb[0].mag);
                    chk("edge", edge_flag, (sb[0].mag >= int'(thresh)));
                    chk("in_ready_in_hold", in_ready, 1'b0);
                    if (out_ready) begin
                        sb.delete(0);
                        xfers++;
                        shown = 1'b0;
                    end else begin
                        shown = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [9*PIX_W-1:0] p, input bit k, input bit ms,
                        output int t, input bit hold);
        int n = 0;
        px = p; kern_sel = k; mag_sel = ms; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", in_ready, 1'b1);
        t = cyc;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", (n < 100), 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, t0, t1, t2, x0, n;
        logic [9*PIX_W-1:0] vert, diag, lcol, corner;
        vert   = win(0, 0, 255, 0, 0, 255, 0, 0, 255);
        diag   = win(0, 0, 255, 0, 0, 0, 0, 0, 0);
        lcol   = win(255, 0, 0, 255, 0, 0, 255, 0, 0);
        corner = win(255, 255, 255, 0, 0, 255, 0, 0, 255);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mag", mag, 0);
        chk("rst_pix_clip", pix_clip, 0);
        chk("rst_edge", edge_flag, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1'b1);
        @(posedge clk); #1;

        // Directed windows (expected 0, 1020, 765, 510, 255, 1020, 1530)
        thresh = 11'd1;   send(win(100,100,100,100,100,100,100,100,100), 0, 0, t, 0); drain();
        thresh = 11'd500; send(vert, 0, 0, t, 0); drain();
        send(vert, 1, 0, t, 0); drain();
        thresh = 11'd510; send(diag, 0, 0, t, 0); drain();
        send(diag, 0, 1, t, 0); drain();
        send(lcol, 0, 1, t, 0); drain();
        thresh = 11'd1530; send(corner, 0, 0, t, 0); drain();

        // Backpressure with inputs and threshold toggling during HOLD
        out_ready = 1'b0; thresh = 11'd500;
        x0 = xfers;
        send(vert, 0, 0, t, 0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait_timeout", out_valid, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            px       = {$urandom(), $urandom(), 8'($urandom())};
            kern_sel = ~kern_sel;
            mag_sel  = ~mag_sel;
            in_valid = ~in_valid;
            thresh   = (i % 2 == 0) ? 11'd1500 : 11'd500;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        chk("bp_single_transfer", xfers - x0, 1);

        // Back-to-back with in_valid held high
        thresh = 11'd300;
        send(vert, 0, 0, t0, 1);
        send(diag, 1, 0, t1, 1);
        send(lcol, 0, 1, t2, 0);
        chk("b2b_spacing_1", t1 - t0, 12);
        chk("b2b_spacing_2", t2 - t1, 12);
        drain();

        // Reset in the middle of MAC discards the window
        send(vert, 0, 0, t, 0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("in_ready_after_mid_reset", in_ready, 1'b1);
        repeat (20) @(negedge clk);
        chk("no_output_after_mid_reset", out_valid, 1'b0);
        @(posedge clk); #1;
        thresh = 11'd510;
        send(diag, 0, 0, t, 0); drain();

        // A few random windows and modes
        for (int i = 0; i < 4; i++) begin
            thresh = 11'($urandom_range(0, 1500));
            send({$urandom(), $urandom(), 8'($urandom())}, 1'($urandom()), 1'($urandom()), t, 0);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
